flit_fifo_buffer: RTL
=====================

// Module: flit_fifo_buffer
// PURPOSE
//   Parametrised N-flit FIFO buffer with valid/ready (send/ready) handshake on both sides.
//   Generalises the router's single-flit register buffer in data width and depth.
//   Sits on router input/output ports, ahead of the crossbar, to absorb back-pressure.
//   Allows back-to-back streaming: 1 flit/cycle in and out at once.
// PARAMETERS
//   DATA_W  64  flit width in bits
//   DEPTH   4   number of flit slots; power of two, >= 2
//   AW      $clog2(DEPTH)  pointer width; derived, do not override
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous active-low reset
//   buffer_en  in   1       transfer enable; 0 freezes both interfaces
//   buffer_di  in   DATA_W  upstream flit data
//   buffer_si  in   1       upstream send (valid)
//   buffer_ri  out  1       ready to upstream
//   buffer_ro  in   1       downstream ready
//   buffer_so  out  1       send (valid) to downstream
//   buffer_do  out  DATA_W  head-of-queue flit
//   buffer_cnt out  AW+1    occupancy (only with FLIT_FIFO_STATUS_EN)
//   buffer_af  out  1       almost full (only with FLIT_FIFO_STATUS_EN)
// BEHAVIOUR
//   - State: mem[DEPTH], wr_ptr/rd_ptr (AW bits), count (AW+1 bits), ri_q, so_q.
//   - Reset (reset=0, async): pointers=0, count=0, mem cleared, ri_q=0, so_q=0.
//     All outputs read 0 during reset. Mid-operation reset discards all stored flits.
//   - buffer_ri = ri_q & buffer_en;  buffer_so = so_q & buffer_en.
//   - buffer_do = mem[rd_ptr] (first-word fall-through); valid only while buffer_so=1.
//   - wr = buffer_si & buffer_ri;  rd = buffer_so & buffer_ro;  both sampled on clk rise.
//   - wr: mem[wr_ptr]<=buffer_di, wr_ptr+1.  rd: rd_ptr+1.  Pointers wrap DEPTH-1 -> 0.
//   - count_next = count + wr - rd.  ri_q <= (count_next != DEPTH).  so_q <= (count_next != 0).
//   - Latency: a flit written in cycle N is first visible on buffer_so/do in cycle N+1.
//   - Empty + wr: no read possible that cycle (so=0); flit is not bypassed.
//   - Full: ri=0, so no write even if rd happens the same cycle. ri returns the cycle after the rd.
//   - Simultaneous wr & rd at 0<count<DEPTH: count unchanged, order preserved.
//   - ri and so are registered. Neither depends combinationally on si or ro.
//   - First cycle after reset release: ri=0. From the second cycle: ri=buffer_en.
//   - buffer_en=0: ri=so=0, no wr/rd, contents and pointers held. Flits resume unchanged on re-enable.
//   - si while ri=0 is ignored; upstream holds the flit. do is held while so=1 & ro=0.
// CONFIGURATION
//   FLIT_FIFO_STATUS_EN defined:
//     - buffer_cnt = count (registered, reset 0).
//     - buffer_af = (count >= DEPTH-1) (registered, reset 0).
//     - Both outputs ignore buffer_en.
//   FLIT_FIFO_STATUS_EN undefined: buffer_cnt and buffer_af ports and logic are absent.
//     Handshake behaviour is identical in both builds.
// TESTING
//   1. Reset then en=1, no si -> cycle1 ri=0, cycle2+ ri=1, so=0, do=0.
//   2. DEPTH=4, ro=0, si=1 with di=1,2,3,4,5 -> 4 accepted, ri=0 after 4th, 5 held; cnt=4, af=1.
//   3. Full, then ro=1 for 4 cycles -> do=1,2,3,4 in order. ri=1 the cycle after 1st rd. so=0 after 4th.
//   4. Steady si=ro=1, incrementing di -> after 1-cycle fill, 1 flit/cycle out, no gaps, order kept.
//      Wrap past ptr 3->0 exercised.
//   5. 2 flits stored, en=0 for 3 cycles with si=ro=1 -> ri=so=0, cnt stays 2. en=1 -> same 2 flits out.
//   6. reset pulsed low mid-stream with 3 flits stored -> so=ri=0 at once, cnt=0. Old flits never reappear.

Source files
------------

// File: rtl/flit_fifo_buffer.sv
// Parametrised flit FIFO with registered send/ready handshake on both sides and first-word fall-through.
// Optional occupancy/almost-full status outputs are built when FLIT_FIFO_STATUS_EN is defined.
module flit_fifo_buffer #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              buffer_en,
    input  logic [DATA_W-1:0] buffer_di,
    input  logic              buffer_si,
    output logic              buffer_ri,
    input  logic              buffer_ro,
    output logic              buffer_so,
    output logic [DATA_W-1:0] buffer_do
`ifdef FLIT_FIFO_STATUS_EN
    ,
    output logic [AW:0]       buffer_cnt,
    output logic              buffer_af
`endif
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST_C = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ZERO_C   = {(AW+1){1'b0}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ri_q, ri_d;
    logic              so_q, so_d;
    logic              wr_s, rd_s;

    // Handshake outputs are registered flags gated only by the enable, so neither ri nor so sees si/ro.
    assign buffer_ri = ri_q & buffer_en;
    assign buffer_so = so_q & buffer_en;
    assign buffer_do = mem_q[rd_ptr_q];

    // Transfer decode, pointer advance and next occupancy / handshake flags.
    always_comb begin
        wr_s     = buffer_si & buffer_ri;
        rd_s     = buffer_so & buffer_ro;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {{AW{1'b0}}, wr_s} - {{AW{1'b0}}, rd_s};
        ri_d    = (count_d != DEPTH_C);
        so_d    = (count_d != ZERO_C);
    end

    // Control state: pointers, occupancy and the registered ready/send flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= ZERO_C;
            ri_q     <= 1'b0;
            so_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ri_q     <= ri_d;
            so_q     <= so_d;
        end
    end

    // Flit storage; cleared on reset so a discarded stream never leaks onto buffer_do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_s) begin
            mem_q[wr_ptr_q] <= buffer_di;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

`ifdef FLIT_FIFO_STATUS_EN
    logic af_q, af_d;

    assign af_d       = (count_d >= ALMOST_C);
    assign buffer_cnt = count_q;
    assign buffer_af  = af_q;

    // Almost-full flag follows the registered occupancy and ignores buffer_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end
`endif

endmodule
